// File: rtl/state_pkg.sv
// Shared definitions for the read-side state primitives: width helpers
// and the common read response record.
package state_pkg;

  // Data field width of the shared read response record.
  // Primitives using it keep their WIDTH at or below this.
  localparam int RESP_DATA_W = 32;

  // Bits needed to address one of `depth` entries.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Bits needed to hold an occupancy from 0 up to `depth`.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Registered answer of a read port: the data plus its qualifiers.
  typedef struct packed {
    logic [RESP_DATA_W-1:0] data;
    logic                   valid;
    logic                   miss;
  } read_resp_t;

endpackage

// File: rtl/history_reader_if.sv
// Bus between a history_reader and its user: the write side, the read
// request and the registered read response.
interface history_reader_if
  import state_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic             write_en;
  logic [WIDTH-1:0] in;
  logic             read_en;
  logic [IDX_W-1:0] read_idx;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_miss;
  logic [CNT_W-1:0] count;

  modport master (
    output write_en, in, read_en, read_idx,
    input  out, out_valid, out_miss, count
  );

  modport slave (
    input  write_en, in, read_en, read_idx,
    output out, out_valid, out_miss, count
  );

endinterface

// File: rtl/history_mem.sv
// DEPTH x WIDTH history storage: one synchronous write port and one
// combinational read port. Contents are deliberately not reset; callers
// decide validity from their own occupancy count.
module history_mem
  import state_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
)(
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [idx_width(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [idx_width(DEPTH):0]   rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  localparam int IDX_W = idx_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Record the incoming sample in its slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read address carries a sign bit from the age arithmetic, so any
  // value outside 0..DEPTH-1 returns zero instead of indexing past the end.
  always_comb begin
    rd_data = '0;
    if (rd_addr < (IDX_W + 1)'(DEPTH)) begin
      rd_data = mem[rd_addr[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/history_reader.sv
// history_reader: circular history of the last DEPTH accepted samples with
// a one-cycle-latency read port addressed by age (0 = most recent).
// Optional feature macro: HISTORY_READER_BYPASS_EN -- when defined, a read
// in the same cycle as a write sees the post-write history; when undefined
// the read sees the pre-write history and no bypass mux exists.
module history_reader
  import state_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
)(
  input  logic clk,
  input  logic reset,
  history_reader_if.slave bus
);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [IDX_W-1:0] wptr;
  logic [IDX_W-1:0] wptr_next;
  logic [IDX_W-1:0] rd_wptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] rd_count;
  logic [IDX_W:0]   raw_slot;
  logic [IDX_W:0]   rd_slot;
  logic [WIDTH-1:0] mem_rd_data;
  logic [WIDTH-1:0] hit_data;
  logic             hit;
  read_resp_t       resp_q;

  history_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (bus.write_en),
    .wr_addr (wptr),
    .wr_data (bus.in),
    .rd_addr (rd_slot),
    .rd_data (mem_rd_data)
  );

  // Post-write pointer and occupancy: pointer wraps at DEPTH-1 (DEPTH need
  // not be a power of two) and occupancy saturates once history is full.
  always_comb begin
    wptr_next  = wptr;
    count_next = count;
    if (bus.write_en) begin
      wptr_next = (wptr == IDX_W'(DEPTH - 1)) ? '0 : wptr + IDX_W'(1);
      if (count != CNT_W'(DEPTH)) begin
        count_next = count + CNT_W'(1);
      end
    end
  end

  // Write pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr_next;
      count <= count_next;
    end
  end

`ifdef HISTORY_READER_BYPASS_EN
  // Reads look at the history as it will be after this cycle's write; the
  // sample being written is not in storage yet, so age 0 takes it directly.
  assign rd_wptr  = wptr_next;
  assign rd_count = count_next;
  assign hit_data = (bus.write_en && (bus.read_idx == '0)) ? bus.in : mem_rd_data;
`else
  // Reads look at the history as it stood before this cycle's write.
  assign rd_wptr  = wptr;
  assign rd_count = count;
  assign hit_data = mem_rd_data;
`endif

  // Slot of age k is (wptr-1-k) mod DEPTH: subtract with a sign bit, then
  // add DEPTH back once if the result went negative. For k >= DEPTH the
  // result can stay out of range, but such reads are misses anyway.
  assign raw_slot = {1'b0, rd_wptr} - {1'b0, bus.read_idx} - (IDX_W + 1)'(1);
  assign rd_slot  = raw_slot[IDX_W] ? raw_slot + (IDX_W + 1)'(DEPTH) : raw_slot;
  assign hit      = CNT_W'(bus.read_idx) < rd_count;

  // Read response register: valid pulses for each read; data and miss
  // hold their last value while no read is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q <= '0;
    end else if (bus.read_en) begin
      resp_q.valid <= 1'b1;
      resp_q.miss  <= !hit;
      resp_q.data  <= hit ? RESP_DATA_W'(hit_data) : '0;
    end else begin
      resp_q.valid <= 1'b0;
    end
  end

  assign bus.out       = resp_q.data[WIDTH-1:0];
  assign bus.out_valid = resp_q.valid;
  assign bus.out_miss  = resp_q.miss;
  assign bus.count     = count;

endmodule

// File: tb/tb_history_reader.sv
// Testbench for history_reader: a DEPTH=8 and a DEPTH=6 instance receive
// identical traffic; a queue-based history model predicts every read
// response into a scoreboard that is popped when the response appears.
module tb_history_reader;

  typedef struct {
    logic        miss;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int tests = 0;
  int fails = 0;

  exp_t        sb8[$];
  exp_t        sb6[$];
  logic [31:0] hist8[$];
  logic [31:0] hist6[$];
  logic [31:0] last_out8  = '0;
  logic [31:0] last_out6  = '0;
  logic        last_miss8 = 1'b0;
  logic        last_miss6 = 1'b0;
  exp_t        e8;
  exp_t        e6;

  history_reader_if #(.WIDTH(32), .DEPTH(8)) bus8 ();
  history_reader_if #(.WIDTH(32), .DEPTH(6)) bus6 ();

  history_reader #(.WIDTH(32), .DEPTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  history_reader #(.WIDTH(32), .DEPTH(6)) dut6 (.clk(clk), .reset(reset), .bus(bus6));

  always #5 clk = ~clk;

  // Expected response for a read of age k; hist holds newest entry first.
  function automatic exp_t predict(input logic [31:0] hist[$], input int depth,
                                   input logic we, input logic [31:0] din, input int k);
    exp_t r;
    int   cnt;
    int   lim;
    cnt    = hist.size();
    r.miss = 1'b1;
    r.data = '0;
`ifdef HISTORY_READER_BYPASS_EN
    if (we) begin
      lim = (cnt + 1 < depth) ? cnt + 1 : depth;
      if (k == 0) begin
        r.miss = 1'b0;
        r.data = din;
      end else if (k < lim) begin
        r.miss = 1'b0;
        r.data = hist[k-1];
      end
      return r;
    end
`endif
    lim = cnt;
    if (k < lim) begin
      r.miss = 1'b0;
      r.data = hist[k];
    end
    return r;
  endfunction

  // Drive one cycle on both instances, predict responses, update the model.
  task automatic step(input logic we, input logic [31:0] din, input logic re, input int k);
    exp_t p8;
    exp_t p6;
    bus8.write_en = we; bus8.in = din; bus8.read_en = re; bus8.read_idx = 3'(k);
    bus6.write_en = we; bus6.in = din; bus6.read_en = re; bus6.read_idx = 3'(k);
    if (re) begin
      p8 = predict(hist8, 8, we, din, k);
      p6 = predict(hist6, 6, we, din, k);
      sb8.push_back(p8);
      sb6.push_back(p6);
      last_out8 = p8.data; last_miss8 = p8.miss;
      last_out6 = p6.data; last_miss6 = p6.miss;
    end
    if (we) begin
      hist8.push_front(din);
      if (hist8.size() > 8) void'(hist8.pop_back());
      hist6.push_front(din);
      if (hist6.size() > 6) void'(hist6.pop_back());
    end
    @(posedge clk);
    #1;
    bus8.write_en = 1'b0; bus8.read_en = 1'b0;
    bus6.write_en = 1'b0; bus6.read_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus8.out_valid !== 1'b0 || bus8.out_miss !== 1'b0 || bus8.out !== 32'd0 || bus8.count !== 4'd0) begin
      fails++;
      $display("[TB] FAIL reset_dut8: valid=%b miss=%b out=%h count=%0d, expected all zero",
               bus8.out_valid, bus8.out_miss, bus8.out, bus8.count);
    end
    tests++;
    if (bus6.out_valid !== 1'b0 || bus6.out_miss !== 1'b0 || bus6.out !== 32'd0 || bus6.count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL reset_dut6: valid=%b miss=%b out=%h count=%0d, expected all zero",
               bus6.out_valid, bus6.out_miss, bus6.out, bus6.count);
    end
    reset = 1'b1;
    step(1'b0, 32'd0, 1'b1, 0);
    e8 = sb8.pop_front();
    e6 = sb6.pop_front();
    tests++;
    if (bus8.out_valid !== 1'b1 || bus8.out_miss !== 1'b1 || bus8.out !== 32'd0 || bus8.count !== 4'd0) begin
      fails++;
      $display("[TB] FAIL empty_read_dut8: valid=%b miss=%b out=%h count=%0d, expected 1 1 0 0",
               bus8.out_valid, bus8.out_miss, bus8.out, bus8.count);
    end
    tests++;
    if (bus6.out_valid !== 1'b1 || bus6.out_miss !== e6.miss || bus6.out !== e6.data) begin
      fails++;
      $display("[TB] FAIL empty_read_dut6: valid=%b miss=%b out=%h, expected 1 %b %h",
               bus6.out_valid, bus6.out_miss, bus6.out, e6.miss, e6.data);
    end
  endtask

  task automatic test_fill();
    int          ks[3]  = '{0, 4, 5};
    logic [31:0] want[3] = '{32'd5, 32'd1, 32'd0};
    logic        wmiss[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 1'b1, ks[i]);
      e8 = sb8.pop_front();
      e6 = sb6.pop_front();
      tests++;
      if (bus8.out_valid !== 1'b1 || bus8.out_miss !== wmiss[i] || bus8.out !== want[i] || bus8.out !== e8.data) begin
        fails++;
        $display("[TB] FAIL fill_k%0d_dut8: valid=%b miss=%b out=%h, expected 1 %b %h",
                 ks[i], bus8.out_valid, bus8.out_miss, bus8.out, wmiss[i], want[i]);
      end
      tests++;
      if (bus6.out_valid !== 1'b1 || bus6.out_miss !== wmiss[i] || bus6.out !== want[i] || bus6.out !== e6.data) begin
        fails++;
        $display("[TB] FAIL fill_k%0d_dut6: valid=%b miss=%b out=%h, expected 1 %b %h",
                 ks[i], bus6.out_valid, bus6.out_miss, bus6.out, wmiss[i], want[i]);
      end
    end
    tests++;
    if (bus8.count !== 4'd5 || bus6.count !== 3'd5) begin
      fails++;
      $display("[TB] FAIL fill_count: dut8=%0d dut6=%0d, expected 5 5", bus8.count, bus6.count);
    end
  endtask

  task automatic test_wrap();
    int          ks[4]  = '{0, 5, 6, 7};
    logic [31:0] w8[4]  = '{32'd11, 32'd6, 32'd5, 32'd4};
    logic [31:0] w6[4]  = '{32'd11, 32'd6, 32'd0, 32'd0};
    logic        m6[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 6; i <= 11; i++) step(1'b1, 32'(i), 1'b0, 0);
    tests++;
    if (bus8.count !== 4'd8 || bus6.count !== 3'd6) begin
      fails++;
      $display("[TB] FAIL wrap_count: dut8=%0d dut6=%0d, expected 8 6", bus8.count, bus6.count);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 1'b1, ks[i]);
      e8 = sb8.pop_front();
      e6 = sb6.pop_front();
      tests++;
      if (bus8.out_valid !== 1'b1 || bus8.out_miss !== 1'b0 || bus8.out !== w8[i] || bus8.out !== e8.data) begin
        fails++;
        $display("[TB] FAIL wrap_k%0d_dut8: valid=%b miss=%b out=%h, expected 1 0 %h",
                 ks[i], bus8.out_valid, bus8.out_miss, bus8.out, w8[i]);
      end
      tests++;
      if (bus6.out_valid !== 1'b1 || bus6.out_miss !== m6[i] || bus6.out !== w6[i] || bus6.out_miss !== e6.miss) begin
        fails++;
        $display("[TB] FAIL wrap_k%0d_dut6: valid=%b miss=%b out=%h, expected 1 %b %h",
                 ks[i], bus6.out_valid, bus6.out_miss, bus6.out, m6[i], w6[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] want0;
    logic [31:0] want1;
`ifdef HISTORY_READER_BYPASS_EN
    want0 = 32'hBB;
    want1 = 32'hAA;
`else
    want0 = 32'hAA;
    want1 = 32'hBB;
`endif
    step(1'b1, 32'hAA, 1'b0, 0);
    step(1'b1, 32'hBB, 1'b1, 0);
    e8 = sb8.pop_front();
    e6 = sb6.pop_front();
    tests++;
    if (bus8.out !== want0 || bus8.out_miss !== 1'b0 || bus6.out !== e6.data || bus8.out !== e8.data) begin
      fails++;
      $display("[TB] FAIL simul_k0: dut8=%h dut6=%h miss=%b, expected %h miss=0", bus8.out, bus6.out, bus8.out_miss, want0);
    end
    step(1'b1, 32'hAA, 1'b0, 0);
    step(1'b1, 32'hBB, 1'b1, 1);
    e8 = sb8.pop_front();
    e6 = sb6.pop_front();
    tests++;
    if (bus8.out !== want1 || bus8.out_miss !== 1'b0 || bus6.out !== e6.data || bus8.out !== e8.data) begin
      fails++;
      $display("[TB] FAIL simul_k1: dut8=%h dut6=%h miss=%b, expected %h miss=0", bus8.out, bus6.out, bus8.out_miss, want1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b1, i % 8);
      e8 = sb8.pop_front();
      e6 = sb6.pop_front();
      tests++;
      if (bus8.out_valid !== 1'b1 || bus8.out_miss !== e8.miss || bus8.out !== e8.data) begin
        fails++;
        $display("[TB] FAIL b2b_%0d_dut8: valid=%b miss=%b out=%h, expected 1 %b %h",
                 i, bus8.out_valid, bus8.out_miss, bus8.out, e8.miss, e8.data);
      end
      tests++;
      if (bus6.out_valid !== 1'b1 || bus6.out_miss !== e6.miss || bus6.out !== e6.data) begin
        fails++;
        $display("[TB] FAIL b2b_%0d_dut6: valid=%b miss=%b out=%h, expected 1 %b %h",
                 i, bus6.out_valid, bus6.out_miss, bus6.out, e6.miss, e6.data);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus8.write_en = 1'b1; bus8.in = 32'h5A; bus8.read_en = 1'b1; bus8.read_idx = 3'd0;
    bus6.write_en = 1'b1; bus6.in = 32'h5A; bus6.read_en = 1'b1; bus6.read_idx = 3'd0;
    #2;
    reset = 1'b0;
    hist8.delete(); hist6.delete(); sb8.delete(); sb6.delete();
    last_out8 = '0; last_out6 = '0; last_miss8 = 1'b0; last_miss6 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus8.write_en = 1'b0; bus8.read_en = 1'b0;
    bus6.write_en = 1'b0; bus6.read_en = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (bus8.out_valid !== 1'b0 || bus8.count !== 4'd0 || bus6.out_valid !== 1'b0 || bus6.count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL midreset_state: valid8=%b count8=%0d valid6=%b count6=%0d, expected 0 0 0 0",
               bus8.out_valid, bus8.count, bus6.out_valid, bus6.count);
    end
    step(1'b0, 32'd0, 1'b1, 0);
    e8 = sb8.pop_front();
    e6 = sb6.pop_front();
    tests++;
    if (bus8.out_valid !== 1'b1 || bus8.out_miss !== 1'b1 || bus8.out !== 32'd0 || bus6.out_miss !== e6.miss) begin
      fails++;
      $display("[TB] FAIL midreset_read: valid=%b miss=%b out=%h, expected 1 1 0",
               bus8.out_valid, bus8.out_miss, bus8.out);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic        re;
    logic [31:0] din;
    int          k;
    for (int i = 0; i < 10000; i++) begin
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      din = $urandom;
      k   = $urandom_range(0, 7);
      step(we, din, re, k);
      if (re) begin
        e8 = sb8.pop_front();
        e6 = sb6.pop_front();
      end else begin
        e8.miss = last_miss8; e8.data = last_out8;
        e6.miss = last_miss6; e6.data = last_out6;
      end
      tests++;
      if (bus8.out_valid !== re || bus8.out_miss !== e8.miss || bus8.out !== e8.data
          || bus8.count !== 4'(hist8.size())) begin
        fails++;
        $display("[TB] FAIL rand_%0d_dut8: valid=%b miss=%b out=%h count=%0d, expected %b %b %h %0d",
                 i, bus8.out_valid, bus8.out_miss, bus8.out, bus8.count, re, e8.miss, e8.data, hist8.size());
      end
      tests++;
      if (bus6.out_valid !== re || bus6.out_miss !== e6.miss || bus6.out !== e6.data
          || bus6.count !== 3'(hist6.size())) begin
        fails++;
        $display("[TB] FAIL rand_%0d_dut6: valid=%b miss=%b out=%h count=%0d, expected %b %b %h %0d",
                 i, bus6.out_valid, bus6.out_miss, bus6.out, bus6.count, re, e6.miss, e6.data, hist6.size());
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    bus8.write_en = 1'b0; bus8.in = '0; bus8.read_en = 1'b0; bus8.read_idx = '0;
    bus6.write_en = 1'b0; bus6.in = '0; bus6.read_en = 1'b0; bus6.read_idx = '0;
    test_reset();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
